// File: rtl/shield_pkg.sv
// Shared constants and FSM state type for the colorshield write arbiter.
package shield_pkg;

    localparam int PIX_W         = 24;
    localparam int ADDR_W        = 6;
    localparam int MATRIX_PIXELS = 64;
    localparam int READY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_LOW  = 2'd2,
        ST_WAIT_HIGH = 2'd3
    } arb_state_e;

endpackage

// File: rtl/shield_write_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request strictly after last_grant, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest hit ends up winning.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand        = (int'(last_grant) + k) % NUM_REQ;
            grant_idx   = req[IDX_W'(cand)] ? IDX_W'(cand) : grant_idx;
            grant_valid = grant_valid | req[IDX_W'(cand)];
        end
    end

endmodule

// File: rtl/shield_write_arbiter.sv
// Round-robin arbiter for the single colorshield pixel-write port.
// Optional full-matrix fill engine enabled by defining SHIELD_ARB_FILL_EN.
module shield_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = shield_pkg::ADDR_W,
    parameter int PIX_W   = shield_pkg::PIX_W,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*PIX_W-1:0]   req_value,
    output logic [NUM_REQ-1:0]         req_ack,
    input  logic                       shield_ready,
    output logic                       write_en,
    output logic [ADDR_W-1:0]          pixel_addr,
    output logic [PIX_W-1:0]           pixel_value,
    output logic                       busy,
`ifdef SHIELD_ARB_FILL_EN
    input  logic                       fill_req,
    input  logic [PIX_W-1:0]           fill_value,
    output logic                       fill_busy,
`endif
    output logic [IDX_W-1:0]           last_grant
);
    import shield_pkg::*;

    localparam int TMO_W  = $clog2(READY_TIMEOUT);
    localparam int FILL_W = $clog2(MATRIX_PIXELS);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PIX_W-1:0]    value_q, value_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                pick_valid_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [PIX_W-1:0]    sel_value_s;

`ifdef SHIELD_ARB_FILL_EN
    logic                fill_busy_q, fill_busy_d;
    logic                fill_last_q, fill_last_d;
    logic [FILL_W-1:0]   fill_addr_q, fill_addr_d;
    logic [PIX_W-1:0]    fill_val_q, fill_val_d;
    logic                fill_done_s;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req         (req_valid),
        .last_grant  (last_q),
        .grant_valid (pick_valid_s),
        .grant_idx   (pick_idx_s)
    );

    assign sel_addr_s  = req_addr[int'(pick_idx_s)*ADDR_W +: ADDR_W];
    assign sel_value_s = req_value[int'(pick_idx_s)*PIX_W +: PIX_W];

    // Next-state and registered-output computation for the write sequencer.
    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        value_d = value_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
`ifdef SHIELD_ARB_FILL_EN
        fill_busy_d = fill_busy_q;
        fill_last_d = fill_last_q;
        fill_addr_d = fill_addr_q;
        fill_val_d  = fill_val_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef SHIELD_ARB_FILL_EN
                // An active fill locks out requesters until the last pixel completes.
                if (fill_busy_q) begin
                    if (shield_ready) begin
                        addr_d      = ADDR_W'(fill_addr_q);
                        value_d     = fill_val_q;
                        fill_addr_d = fill_addr_q + FILL_W'(1);
                        fill_last_d = (fill_addr_q == FILL_W'(MATRIX_PIXELS - 1));
                        state_d     = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (fill_req) begin
                    fill_busy_d = 1'b1;
                    fill_addr_d = '0;
                    fill_val_d  = fill_value;
                    state_d     = ST_IDLE;
                end else
`endif
                if (shield_ready && pick_valid_s) begin
                    addr_d            = sel_addr_s;
                    value_d           = sel_value_s;
                    last_d            = pick_idx_s;
                    ack_d[pick_idx_s] = 1'b1;
                    state_d           = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                we_d    = 1'b1;
                tmo_d   = '0;
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                // A shield that finishes inside one cycle never shows ready low.
                if (!shield_ready) begin
                    state_d = ST_WAIT_HIGH;
                end else if (tmo_q == TMO_W'(READY_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (shield_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef SHIELD_ARB_FILL_EN
        fill_done_s = fill_last_q && (state_q != ST_IDLE) && (state_d == ST_IDLE);
        fill_busy_d = fill_busy_d & ~fill_done_s;
        fill_last_d = fill_last_d & ~fill_done_s;
`endif
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            value_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            value_q <= value_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef SHIELD_ARB_FILL_EN
    // Fill engine registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_busy_q <= 1'b0;
            fill_last_q <= 1'b0;
            fill_addr_q <= '0;
            fill_val_q  <= '0;
        end else begin
            fill_busy_q <= fill_busy_d;
            fill_last_q <= fill_last_d;
            fill_addr_q <= fill_addr_d;
            fill_val_q  <= fill_val_d;
        end
    end

    assign fill_busy = fill_busy_q;
`endif

    assign req_ack     = ack_q;
    assign write_en    = we_q;
    assign busy        = busy_q;
    assign pixel_addr  = addr_q;
    assign pixel_value = value_q;
    assign last_grant  = last_q;

endmodule

// File: doc/shield_write_arbiter.md
Name: shield_write_arbiter

Overview:
- Round-robin arbiter that shares the single colorshield pixel-write port between NUM_REQ independent requesters, e.g. an animation engine, a text overlay and a debug poker.
- Sits between the requesters and the colorshield instance, and drives its write_en, pixel_addr and pixel_value.
- Sequences each write against the shield's ready signal, so that only one pixel update is in flight at a time.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 6, pixel address width (8x8 matrix: {row[2:0], col[2:0]}).
- PIX_W, 24, pixel value width (RGB 8:8:8, R in [23:16]).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_value  in  NUM_REQ*PIX_W  packed pixel values; requester i uses bits [i*PIX_W +: PIX_W].
- req_ack  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- shield_ready  in  1  colorshield idle/ready.
- write_en  out  1  write strobe to colorshield.
- pixel_addr  out  ADDR_W  address to colorshield.
- pixel_value  out  PIX_W  value to colorshield.
- busy  out  1  a write is in flight (state != IDLE).
- last_grant  out  $clog2(NUM_REQ)  index of the most recent grant.

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk. All state is on posedge clk.
- Reset values:
  - state = IDLE.
  - write_en, req_ack, busy = 0.
  - pixel_addr = 0, pixel_value = 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
- Requester rule: a requester holds req_valid, addr and value stable until it sees its req_ack. It may drop req_valid at any time before the ack (withdraw); the arbiter only samples on the grant cycle.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - If shield_ready=1 and any req_valid: pick the first set bit scanning last_grant+1, last_grant+2, … modulo NUM_REQ.
  - Register that requester's addr/value into pixel_addr/pixel_value, update last_grant, pulse req_ack[i] for 1 cycle, go to ISSUE.
  - If shield_ready=0 or no request: stay in IDLE; outputs hold their last values.
- ISSUE: write_en=1 for exactly this one cycle, then go to WAIT_LOW.
- WAIT_LOW: stay until shield_ready=0 (the shield has accepted the write), then go to WAIT_HIGH.
  - Timeout: if shield_ready stays 1 for 4 cycles in WAIT_LOW, treat the write as consumed and go to IDLE. This covers a shield that completes within a cycle.
- WAIT_HIGH: stay until shield_ready=1, then go to IDLE. The next grant can occur in that IDLE cycle at the earliest.
- Latency: 1 cycle from request (IDLE, shield ready) to req_ack; write_en follows 1 cycle after req_ack.
- pixel_addr and pixel_value are stable from the ISSUE cycle until the next grant.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,… No requester waits more than NUM_REQ-1 writes.
- Single requester: it is granted back-to-back, limited only by shield_ready.
- A request arriving while busy waits; there is no queueing beyond requesters holding valid.
- Reset mid-write: the FSM returns to IDLE and write_en is dropped immediately (asynchronous). Any requester whose ack was already given has had its write lost; this is acceptable.

Optional Feature:
- Macro SHIELD_ARB_FILL_EN.
- When defined:
  - Extra ports: fill_req (in, 1), fill_value (in, PIX_W), fill_busy (out, 1).
  - A fill_req pulse seen in IDLE starts a fill: addresses 0..63 are written in order with fill_value, each through the same ISSUE / WAIT_LOW / WAIT_HIGH sequence.
  - Fill has absolute priority over requesters. No req_ack is given while fill_busy=1.
  - fill_busy goes high the cycle after fill_req is accepted and low on the return to IDLE after address 63.
  - The 6-bit address counter wraps to 0 after 63.
  - fill_req asserted during a fill is ignored.
- When not defined: none of these ports or logic exist.

Decomposition:
- Package shield_pkg:
  - localparams PIX_W=24, ADDR_W=6, MATRIX_PIXELS=64, READY_TIMEOUT=4.
  - arbiter state enum typedef.
- Sub-module rr_pick: combinational rotating-priority encoder. Inputs: req vector and last_grant. Outputs: grant_valid and grant_idx.

Test Plan:
- Single requester 0 writes addr 6'h07 with 24'hFF0000; shield model drops ready for 10 cycles → req_ack[0] then 1-cycle write_en with pixel_addr=7 and pixel_value=FF0000; busy high until ready returns.
- All three requesters held valid for 6 writes → grant order 0,1,2,0,1,2; exactly one write_en per shield ready cycle.
- Requester 1 drops valid before its grant while 0 and 2 stay valid → grants go 0,2,0; no req_ack[1].
- Shield keeps ready=1 after write_en → FSM returns to IDLE after 4 WAIT_LOW cycles; the next grant proceeds.
- rst_n asserted during WAIT_HIGH → write_en=0 and busy=0 immediately; after release, requester 0 gets first grant.
- With SHIELD_ARB_FILL_EN: fill_req with 24'h00FF00 while requester 2 is valid → 64 writes to addresses 0..63, then requester 2 is acked.
